uc: RTL and testbench

Control unit for the microc single-cycle microcontroller: it sits directly upstream of the datapath. It consumes the datapath's `opcode` and `z` flag and drives the datapath control lines `s_inc`, `s_inm`, `we3`, `wez` and `op`. It adds a RUN/HALT state machine, a sticky illegal-opcode flag, and saturating instruction and taken-jump counters for debug and verification.

---
 rtl/uc.sv | 121 ++++++++++++
 tb/tb_uc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uc.sv
`default_nettype none
// ============================================================================
// Module   : uc
// Purpose  : microc control unit - combinational decode, RUN/HALT FSM,
//            sticky illegal-opcode flag, saturating instruction/jump counters.
// Revision : 1.0
// ============================================================================
module uc #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] jmp_cnt
);

    localparam logic [0:0]       ST_RUN  = 1'b0;
    localparam logic [0:0]       ST_HALT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [5:0]       OPC_HALT = 6'b000111;

    logic [0:0]       state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] jmp_cnt_q, jmp_cnt_d;

    logic             dec_s_inc;
    logic             dec_s_inm;
    logic             dec_we3;
    logic             dec_wez;
    logic [2:0]       dec_op;
    logic             dec_undef;

    // Reset gating keeps the control word at zero asynchronously while reset is held.
    always_comb begin
        dec_s_inc = 1'b0;
        dec_s_inm = 1'b0;
        dec_we3   = 1'b0;
        dec_wez   = 1'b0;
        dec_op    = 3'b000;
        dec_undef = 1'b0;
        if (!reset && (state_q == ST_RUN)) begin
            if (opcode[5]) begin
                dec_we3   = 1'b1;
                dec_wez   = 1'b1;
                dec_s_inc = 1'b1;
                dec_op    = opcode[4:2];
            end else if (opcode[4:2] == 3'b000) begin
                dec_we3   = 1'b1;
                dec_s_inm = 1'b1;
                dec_s_inc = 1'b1;
            end else if (opcode[4:2] == 3'b001) begin
                case (opcode[1:0])
                    2'b00:   dec_s_inc = 1'b0;
                    2'b01:   dec_s_inc = ~z;
                    2'b10:   dec_s_inc = z;
                    default: dec_s_inc = 1'b0;
                endcase
            end else begin
                dec_s_inc = 1'b1;
                dec_undef = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        instr_cnt_d = instr_cnt_q;
        jmp_cnt_d   = jmp_cnt_q;
        if (state_q == ST_RUN) begin
            if (opcode == OPC_HALT) begin
                state_d = ST_HALT;
            end
            if (dec_undef) begin
                illegal_d = 1'b1;
            end
            if (instr_cnt_q != CNT_MAX) begin
                instr_cnt_d = instr_cnt_q + 1'b1;
            end
            if (!dec_s_inc && (jmp_cnt_q != CNT_MAX)) begin
                jmp_cnt_d = jmp_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            illegal_q   <= 1'b0;
            instr_cnt_q <= '0;
            jmp_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            illegal_q   <= illegal_d;
            instr_cnt_q <= instr_cnt_d;
            jmp_cnt_q   <= jmp_cnt_d;
        end
    end

    assign s_inc     = dec_s_inc;
    assign s_inm     = dec_s_inm;
    assign we3       = dec_we3;
    assign wez       = dec_wez;
    assign op        = dec_op;
    assign halted    = (state_q == ST_HALT);
    assign illegal   = illegal_q;
    assign instr_cnt = instr_cnt_q;
    assign jmp_cnt   = jmp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uc.sv
`default_nettype none
// ============================================================================
// Module   : tb_uc
// Purpose  : scoreboard bench for uc with a behavioural reference model.
// Revision : 1.0
// ============================================================================
module tb_uc;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
        logic       halted;
        logic       illegal;
        logic [3:0] ic;
        logic [3:0] jc;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [5:0]       opcode;
    logic             z;
    logic             s_inc, s_inm, we3, wez;
    logic [2:0]       op;
    logic             halted, illegal;
    logic [CNT_W-1:0] instr_cnt, jmp_cnt;

    int tests_run = 0;
    int tests_fail = 0;

    exp_t sb_q[$];

    // Reference machine state
    bit m_halt;
    bit m_ill;
    int m_ic;
    int m_jc;

    uc #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .z         (z),
        .s_inc     (s_inc),
        .s_inm     (s_inm),
        .we3       (we3),
        .wez       (wez),
        .op        (op),
        .halted    (halted),
        .illegal   (illegal),
        .instr_cnt (instr_cnt),
        .jmp_cnt   (jmp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_defined(input logic [5:0] o);
        return (o[5] == 1'b1) || (o[5:2] == 4'b0000) || (o[5:2] == 4'b0001);
    endfunction

    // Control word as {s_inc, s_inm, we3, wez, op}
    function automatic logic [6:0] ref_ctrl(input logic [5:0] o, input logic zz);
        if (o[5])                return {4'b1011, o[4:2]};
        if (o[5:2] == 4'b0000)   return {4'b1110, 3'b000};
        if (o == 6'b000100)      return 7'b0;
        if (o == 6'b000101)      return {~zz, 6'b0};
        if (o == 6'b000110)      return {zz, 6'b0};
        if (o == 6'b000111)      return 7'b0;
        return {1'b1, 6'b0};
    endfunction

    task automatic step(input logic r, input logic [5:0] o, input logic zz);
        logic [6:0] c;
        exp_t e;
        @(posedge clk);
        #1;
        reset  = r;
        opcode = o;
        z      = zz;
        if (r) begin
            m_halt = 0; m_ill = 0; m_ic = 0; m_jc = 0;
        end
        c = (r || m_halt) ? 7'b0 : ref_ctrl(o, zz);
        e.s_inc   = c[6];
        e.s_inm   = c[5];
        e.we3     = c[4];
        e.wez     = c[3];
        e.op      = c[2:0];
        e.halted  = m_halt;
        e.illegal = m_ill;
        e.ic      = 4'(m_ic);
        e.jc      = 4'(m_jc);
        sb_q.push_back(e);
        if (!r && !m_halt) begin
            if (m_ic < CMAX) m_ic++;
            if (!c[6] && m_jc < CMAX) m_jc++;
            if (!is_defined(o)) m_ill = 1;
            if (o == 6'b000111) m_halt = 1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = {s_inc, s_inm, we3, wez, op, halted, illegal, instr_cnt, jmp_cnt};
            tests_run++;
            if (a !== e) begin
                tests_fail++;
                $display("FAIL cycle@%0t opc=%b z=%b rst=%b: got s_inc=%b s_inm=%b we3=%b wez=%b op=%b halted=%b illegal=%b ic=%0d jc=%0d, expected s_inc=%b s_inm=%b we3=%b wez=%b op=%b halted=%b illegal=%b ic=%0d jc=%0d",
                         $time, opcode, z, reset,
                         a.s_inc, a.s_inm, a.we3, a.wez, a.op, a.halted, a.illegal, a.ic, a.jc,
                         e.s_inc, e.s_inm, e.we3, e.wez, e.op, e.halted, e.illegal, e.ic, e.jc);
            end
        end
    end

    logic [5:0] valid_ops [8] = '{6'b100101, 6'b000011, 6'b101000, 6'b101100,
                                  6'b000100, 6'b000101, 6'b000110, 6'b111011};

    initial begin
        reset  = 1'b1;
        opcode = 6'b100101;
        z      = 1'b0;

        // Reset and first instruction after release
        step(1'b1, 6'b100101, 1'b0);
        step(1'b1, 6'b100101, 1'b1);
        step(1'b0, 6'b100101, 1'b0);
        // Decode sweep
        step(1'b0, 6'b000011, 1'b0);
        step(1'b0, 6'b101000, 1'b0);
        step(1'b0, 6'b101100, 1'b0);
        // Conditional jumps
        step(1'b0, 6'b000110, 1'b0);
        step(1'b0, 6'b000110, 1'b1);
        step(1'b0, 6'b000101, 1'b1);
        step(1'b0, 6'b000101, 1'b0);
        step(1'b0, 6'b000100, 1'b0);
        // Halt then frozen
        step(1'b0, 6'b000111, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, (i % 2 == 0) ? 6'b101000 : 6'b000011, 1'(i));
        // Reset out of HALT, then illegal opcode stays sticky
        step(1'b1, 6'b101000, 1'b0);
        step(1'b0, 6'b010000, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, valid_ops[$urandom_range(0, 7)], 1'($urandom));
        step(1'b0, 6'b001011, 1'b1);
        // Saturation, then halt with both counters at maximum
        step(1'b1, 6'b000100, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 6'b000100, 1'b0);
        step(1'b0, 6'b000111, 1'b0);
        step(1'b0, 6'b100000, 1'b0);
        step(1'b0, 6'b000100, 1'b0);
        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 24) == 0), 6'($urandom_range(0, 63)), 1'($urandom));
        end

        @(negedge clk);
        #1;
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
`default_nettype wire
